// File: rtl/hex_effect_scheduler.sv
// Effect sequencer for the 8-digit HEX board: effect index, start pulse, blank gap, tick strobes.
// Latency: key/done pulse in cycle N gives new effect and blank in N+1; no backpressure, pulses are never queued.
// Optional EFFECT_MASK_EN adds effect_mask[15:0] to skip ineligible effects on next/prev.
module hex_effect_scheduler #(
    parameter int TICK_LOG2   = 22,
    parameter int DWELL_TICKS = 32,
    parameter int BLANK_TICKS = 2,
    parameter int NUM_EFFECTS = 15
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        key_next,
    input  logic        key_prev,
    input  logic        key_pause,
    input  logic        effect_done,
`ifdef EFFECT_MASK_EN
    input  logic [15:0] effect_mask,
`endif
    output logic [3:0]  effect,
    output logic        effect_start,
    output logic        blank,
    output logic        paused,
    output logic        tick,
    output logic        tick_x4,
    output logic [7:0]  dwell_left
);

    typedef enum logic [1:0] {ST_BLANK, ST_RUN, ST_PAUSE} state_t;

    localparam logic [3:0] BLANK_LD = 4'(BLANK_TICKS);
    localparam logic [7:0] DWELL_LD = 8'(DWELL_TICKS);
    localparam logic [3:0] LAST_IDX = 4'(NUM_EFFECTS - 1);

    logic [TICK_LOG2-1:0] pre_q, pre_d;
    logic [1:0]           tcnt_q, tcnt_d;
    logic                 tick_q, tick_d;
    logic                 tick_x4_q, tick_x4_d;
    state_t               state_q, state_d;
    logic [3:0]           blank_cnt_q, blank_cnt_d;
    logic [7:0]           dwell_q, dwell_d;
    logic [3:0]           effect_q, effect_d;
    logic                 start_q, start_d;
    logic                 blank_q, blank_d;
    logic                 paused_q, paused_d;
    logic                 pre_wrap;
    logic [3:0]           nxt_idx, prv_idx;
    logic                 go_next, go_prev;

    function automatic logic [3:0] step_idx(input logic [3:0] cur, input logic fwd);
        if (fwd) return (cur == LAST_IDX) ? 4'd0 : cur + 4'd1;
        else     return (cur == 4'd0) ? LAST_IDX : cur - 4'd1;
    endfunction

`ifdef EFFECT_MASK_EN
    localparam logic [15:0] VALID_MASK = 16'((17'd1 << NUM_EFFECTS) - 17'd1);

    // Walk up to a full lap; landing back on cur means nothing else is eligible.
    function automatic logic [3:0] seek_idx(input logic [3:0] cur, input logic fwd,
                                            input logic [15:0] mask);
        logic [15:0] m;
        logic [3:0]  idx;
        logic [3:0]  res;
        logic        found;
        m = mask & VALID_MASK;
        if (m == 16'd0) m = 16'hFFFF;
        idx   = cur;
        res   = cur;
        found = 1'b0;
        for (int i = 0; i < NUM_EFFECTS; i++) begin
            idx = step_idx(idx, fwd);
            if (!found && m[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign nxt_idx = seek_idx(effect_q, 1'b1, effect_mask);
    assign prv_idx = seek_idx(effect_q, 1'b0, effect_mask);
`else
    assign nxt_idx = step_idx(effect_q, 1'b1);
    assign prv_idx = step_idx(effect_q, 1'b0);
`endif

    assign pre_wrap = &pre_q;

    always_comb begin
        pre_d     = pre_q + TICK_LOG2'(1);
        tcnt_d    = pre_wrap ? tcnt_q + 2'd1 : tcnt_q;
        tick_d    = pre_wrap;
        tick_x4_d = pre_wrap && (tcnt_q == 2'd3);
    end

    // Run-state event resolution: next > prev > done > dwell expiry.
    assign go_next = key_next | (~key_prev & (effect_done | (tick_q & (dwell_q == 8'd1))));
    assign go_prev = ~key_next & key_prev;

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        dwell_d     = dwell_q;
        effect_d    = effect_q;
        start_d     = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (key_next) begin
                    effect_d    = nxt_idx;
                    blank_cnt_d = BLANK_LD;
                end else if (key_prev) begin
                    effect_d    = prv_idx;
                    blank_cnt_d = BLANK_LD;
                end else if (blank_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                    dwell_d = DWELL_LD;
                    start_d = 1'b1;
                end else if (tick_q) begin
                    blank_cnt_d = blank_cnt_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (key_pause) begin
                    state_d = ST_PAUSE;
                end else if (go_next || go_prev) begin
                    effect_d    = go_next ? nxt_idx : prv_idx;
                    state_d     = ST_BLANK;
                    blank_cnt_d = BLANK_LD;
                    dwell_d     = 8'd0;
                end else if (tick_q) begin
                    dwell_d = dwell_q - 8'd1;
                end
            end
            ST_PAUSE: begin
                if (key_pause) begin
                    state_d = ST_RUN;
                end else if (key_next || key_prev) begin
                    effect_d    = key_next ? nxt_idx : prv_idx;
                    state_d     = ST_BLANK;
                    blank_cnt_d = BLANK_LD;
                    dwell_d     = 8'd0;
                end
            end
            default: begin
                state_d     = ST_BLANK;
                blank_cnt_d = BLANK_LD;
            end
        endcase
        blank_d  = (state_d == ST_BLANK);
        paused_d = (state_d == ST_PAUSE);
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            pre_q       <= '0;
            tcnt_q      <= 2'd0;
            tick_q      <= 1'b0;
            tick_x4_q   <= 1'b0;
            state_q     <= ST_BLANK;
            blank_cnt_q <= BLANK_LD;
            dwell_q     <= 8'd0;
            effect_q    <= 4'd0;
            start_q     <= 1'b0;
            blank_q     <= 1'b1;
            paused_q    <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            tcnt_q      <= tcnt_d;
            tick_q      <= tick_d;
            tick_x4_q   <= tick_x4_d;
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            dwell_q     <= dwell_d;
            effect_q    <= effect_d;
            start_q     <= start_d;
            blank_q     <= blank_d;
            paused_q    <= paused_d;
        end
    end

    assign effect       = effect_q;
    assign effect_start = start_q;
    assign blank        = blank_q;
    assign paused       = paused_q;
    assign tick         = tick_q;
    assign tick_x4      = tick_x4_q;
    assign dwell_left   = dwell_q;

endmodule
